// File: rtl/sa_pkg.sv
// Shared types and constants for the serial-adder host.
package sa_pkg;

  localparam int unsigned DEF_WIDTH  = 4;
  localparam int unsigned DEF_SA_LAT = 1;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SHIFT,
    DRAIN,
    DONE
  } state_t;

  // Width of the cycle counter that spans SHIFT plus DRAIN.
  function automatic int unsigned cnt_width(input int unsigned w, input int unsigned l);
    return $clog2(w + l + 1);
  endfunction

endpackage

// File: rtl/sa_piso_sipo.sv
// Generic shift register: parallel load, STEP bits out at the LSB end,
// STEP bits in at the MSB end.
module sa_piso_sipo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             shift,
  input  logic [STEP-1:0]  sin,
  output logic [STEP-1:0]  sout,
  output logic [WIDTH-1:0] q
);

  // Load has priority over shift; shifting moves data toward the LSB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {sin, q[WIDTH-1:STEP]};
    end
  end

  assign sout = q[STEP-1:0];

endmodule

// File: rtl/sa_host.sv
// Parallel-side host for the bit-serial adder: takes an operand pair through
// a valid/ready handshake, streams it LSB-first into the adder, collects the
// serial sum and carry-out, and returns the parallel result.
module sa_host
  import sa_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned SA_LAT = DEF_SA_LAT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH:0]   res_sum,
  output logic             sa_reset,
  output logic             sa_a,
  output logic             sa_b,
  output logic             sa_cin,
  input  logic             sa_s,
  input  logic             sa_cout
);

  localparam int unsigned    CW         = cnt_width(WIDTH, SA_LAT);
  localparam logic [CW-1:0]  LAST_SHIFT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  LAST_CAP   = CW'(WIDTH + SA_LAT - 1);

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic                cin_q;
  logic                cout_q;
  logic [2*WIDTH-1:0]  ab_din;
  logic [2*WIDTH-1:0]  ab_unused;
  logic [1:0]          ab_sout;
  logic [WIDTH-1:0]    sum_q;
  logic                sum_sout_unused;
  logic                accept, run, cap_ok, capture, feed;
  logic                op_ready_nxt, res_valid_nxt, sa_reset_nxt;
  logic                sa_a_nxt, sa_b_nxt, sa_cin_nxt;

  // A and B share one register, interleaved {b[i], a[i]} so that each
  // two-bit shift presents the next bit pair at the LSB end.
  always_comb begin
    ab_din = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      ab_din[2*i]   = op_a[i];
      ab_din[2*i+1] = op_b[i];
    end
  end

  // Sum bits arrive from SA_LAT cycles into the stream onward.
  if (SA_LAT == 0) begin : g_nolat
    assign cap_ok = 1'b1;
  end else begin : g_lat
    assign cap_ok = (cnt >= CW'(SA_LAT));
  end

  assign accept  = op_valid && op_ready;
  assign run     = (state == SHIFT) || (state == DRAIN);
  assign capture = run && cap_ok;

  // Next state, plus next values of the registered outputs.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = CLR;
      CLR:     state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST_SHIFT) state_nxt = (SA_LAT == 0) ? DONE : DRAIN;
      DRAIN:   if (cnt == LAST_CAP) state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    feed          = (state_nxt == SHIFT);
    op_ready_nxt  = (state_nxt == IDLE);
    res_valid_nxt = (state_nxt == DONE);
    sa_reset_nxt  = !((state_nxt == SHIFT) || (state_nxt == DRAIN));
    sa_a_nxt      = feed & ab_sout[0];
    sa_b_nxt      = feed & ab_sout[1];
    sa_cin_nxt    = (state == CLR) & cin_q;
  end

  // State, counter, carry latches and every handshake/serial output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cin_q     <= 1'b0;
      cout_q    <= 1'b0;
      op_ready  <= 1'b1;
      res_valid <= 1'b0;
      sa_reset  <= 1'b1;
      sa_a      <= 1'b0;
      sa_b      <= 1'b0;
      sa_cin    <= 1'b0;
    end else begin
      state     <= state_nxt;
      op_ready  <= op_ready_nxt;
      res_valid <= res_valid_nxt;
      sa_reset  <= sa_reset_nxt;
      sa_a      <= sa_a_nxt;
      sa_b      <= sa_b_nxt;
      sa_cin    <= sa_cin_nxt;
      if (accept) cin_q <= op_cin;
      if (state == CLR) cnt <= '0;
      else if (run) cnt <= cnt + CW'(1);
      if (capture && (cnt == LAST_CAP)) cout_q <= sa_cout;
    end
  end

  sa_piso_sipo #(.WIDTH(2 * WIDTH), .STEP(2)) u_ops (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .din   (ab_din),
    .shift (feed),
    .sin   (2'b00),
    .sout  (ab_sout),
    .q     (ab_unused)
  );

  sa_piso_sipo #(.WIDTH(WIDTH), .STEP(1)) u_sum (
    .clk   (clk),
    .reset (reset),
    .load  (1'b0),
    .din   ('0),
    .shift (capture),
    .sin   (sa_s),
    .sout  (sum_sout_unused),
    .q     (sum_q)
  );

  assign res_sum = {cout_q, sum_q};

endmodule

// File: tb/tb_sa_host.sv
// Bench for sa_host: four builds (WIDTH/SA_LAT = 4/1, 5/1, 4/0, 4/2), each
// wired to a behavioural serial adder, with a queue scoreboard fed on
// operand acceptance and drained by a monitor on result presentation.
module tb_sa_host;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  task automatic check(input int g, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL cfg%0d %s: got 0x%0h, expected 0x%0h at %0t", g, name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int unsigned W   = (g == 1) ? 5 : 4;
    localparam int unsigned L   = (g == 2) ? 0 : ((g == 3) ? 2 : 1);
    localparam int unsigned LAT = 1 + W + L;
    localparam logic [W-1:0] DA   = (W == 5) ? W'(27) : W'(15);
    localparam logic [W-1:0] DB   = (W == 5) ? W'(17) : W'(13);
    localparam logic [W:0]   DEXP = (W == 5) ? (W+1)'(45) : (W+1)'(29);

    logic           rst_n = 1'b0;
    logic           op_valid = 1'b0, op_ready, op_cin = 1'b0;
    logic [W-1:0]   op_a = '0, op_b = '0;
    logic           res_valid, res_ready = 1'b0;
    logic [W:0]     res_sum;
    logic           sa_reset, sa_a, sa_b, sa_cin, sa_s, sa_cout;

    sa_host #(.WIDTH(W), .SA_LAT(L)) u_dut (
      .clk       (clk),
      .reset     (rst_n),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .op_cin    (op_cin),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_sum   (res_sum),
      .sa_reset  (sa_reset),
      .sa_a      (sa_a),
      .sa_b      (sa_b),
      .sa_cin    (sa_cin),
      .sa_s      (sa_s),
      .sa_cout   (sa_cout)
    );

    // Behavioural serial adder: carry state, cin folded into the first bit,
    // sum/carry-out delayed by L cycles.
    logic c_reg = 1'b0, ce, s_c, co_c;
    logic s1 = 1'b0, s2 = 1'b0, c1 = 1'b0, c2 = 1'b0;
    always_comb begin
      ce   = c_reg | sa_cin;
      s_c  = sa_a ^ sa_b ^ ce;
      co_c = (sa_a & sa_b) | (ce & (sa_a ^ sa_b));
    end
    always @(posedge clk) begin
      c_reg <= sa_reset ? 1'b0 : co_c;
      s1 <= s_c;  s2 <= s1;
      c1 <= co_c; c2 <= c1;
    end
    assign sa_s    = (L == 0) ? s_c  : ((L == 1) ? s1 : s2);
    assign sa_cout = (L == 0) ? co_c : ((L == 1) ? c1 : c2);

    logic [W:0]   exp_q[$];
    int           in_flight = 0, acc_cyc = 0, cyc = 0, bit_idx = 0;
    int           n_acc = 0, n_res = 0;
    logic         prev_valid = 1'b0;
    logic [W-1:0] cur_a = '0, cur_b = '0;
    logic         cur_c = 1'b0;
    logic [W:0]   last_sum = '0;

    initial forever begin
      @(posedge clk);
      cyc++;
    end

    // Monitor: samples on the falling edge, ahead of the next active edge.
    initial forever begin
      @(negedge clk);
      if (rst_n) begin
        check(g, "op_ready_only_idle", op_ready, (in_flight == 0));
        if (!sa_reset) begin
          if (bit_idx < W) begin
            check(g, "sa_a_bit", sa_a, cur_a[bit_idx]);
            check(g, "sa_b_bit", sa_b, cur_b[bit_idx]);
            check(g, "sa_cin_bit", sa_cin, (bit_idx == 0) ? cur_c : 1'b0);
          end else begin
            check(g, "drain_zero", {sa_a, sa_b, sa_cin}, 0);
          end
          bit_idx++;
        end else begin
          if (bit_idx != 0 && res_valid) check(g, "stream_len", bit_idx, W + L);
          bit_idx = 0;
        end
        if (res_valid) begin
          if (exp_q.size() == 0) begin
            check(g, "unexpected_result", res_valid, 0);
          end else begin
            if (!prev_valid) check(g, "latency", cyc - acc_cyc, LAT);
            check(g, "res_sum", res_sum, exp_q[0]);
            check(g, "done_sa_reset", sa_reset, 1);
            if (res_ready) begin
              void'(exp_q.pop_front());
              in_flight = 0;
              n_res++;
            end
          end
        end
        prev_valid = res_valid;
        if (op_valid && op_ready) begin
          exp_q.push_back((W+1)'(op_a) + (W+1)'(op_b) + (W+1)'(op_cin));
          cur_a = op_a; cur_b = op_b; cur_c = op_cin;
          in_flight = 1;
          acc_cyc = cyc + 1;
          n_acc++;
        end
      end else begin
        prev_valid = 1'b0;
        bit_idx = 0;
      end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      int t = 0;
      op_a = a; op_b = b; op_cin = c; op_valid = 1'b1;
      @(negedge clk);
      while (!op_ready && t < 200) begin @(negedge clk); t++; end
      if (!op_ready) check(g, "accept_timeout", op_ready, 1);
      @(posedge clk); #1;
    endtask

    task automatic wait_valid();
      int t = 0;
      @(negedge clk);
      while (!res_valid && t < 200) begin @(negedge clk); t++; end
      if (!res_valid) check(g, "valid_timeout", res_valid, 1);
      last_sum = res_sum;
    endtask

    task automatic wait_idle();
      int t = 0;
      @(negedge clk);
      while (in_flight != 0 && t < 200) begin @(negedge clk); t++; end
      if (in_flight != 0) check(g, "idle_timeout", in_flight, 0);
      @(posedge clk); #1;
    endtask

    task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      send(a, b, c);
      op_valid = 1'b0;
      wait_valid();
      wait_idle();
    endtask

    task automatic check_reset_outputs(input string tag);
      check(g, {tag, "_op_ready"}, op_ready, 1);
      check(g, {tag, "_res_valid"}, res_valid, 0);
      check(g, {tag, "_res_sum"}, res_sum, 0);
      check(g, {tag, "_sa_reset"}, sa_reset, 1);
      check(g, {tag, "_sa_abc"}, {sa_a, sa_b, sa_cin}, 0);
    endtask

    initial begin
      logic [W:0] snap;
      int a0, r0, t;
      repeat (3) @(posedge clk);
      #1 check_reset_outputs("rst");
      rst_n = 1'b1;
      res_ready = 1'b1;

      // Directed vectors, cross-checked against fixed arithmetic.
      run_one(DA, DB, 1'b1);
      check(g, "dir_sum", last_sum, DEXP);
      run_one('1, '1, 1'b1);
      check(g, "max_sum", last_sum, {(W+1){1'b1}});

      // Back-to-back with op_valid held and res_ready always high.
      a0 = n_acc; r0 = n_res;
      for (int i = 0; i < 3; i++) send(W'($urandom), W'($urandom), 1'($urandom));
      op_valid = 1'b0;
      wait_idle();
      check(g, "b2b_accepts", n_acc - a0, 3);
      check(g, "b2b_results", n_res - r0, 3);

      // Backpressure held for ten cycles in DONE.
      res_ready = 1'b0;
      send(W'($urandom), W'($urandom), 1'($urandom));
      op_valid = 1'b0;
      wait_valid();
      snap = res_sum;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        check(g, "bp_valid", res_valid, 1);
        check(g, "bp_sum_stable", res_sum, snap);
        check(g, "bp_sa_reset", sa_reset, 1);
        check(g, "bp_op_ready", op_ready, 0);
      end
      @(posedge clk); #1 res_ready = 1'b1;
      @(posedge clk); #1;
      check(g, "bp_release_valid", res_valid, 0);
      check(g, "bp_release_ready", op_ready, 1);

      // Asynchronous reset during serial bit 2.
      send(W'($urandom), W'($urandom), 1'b1);
      op_valid = 1'b0;
      t = 0;
      @(negedge clk);
      while (sa_reset && t < 50) begin @(negedge clk); t++; end
      check(g, "shift_started", sa_reset, 0);
      @(negedge clk);
      @(negedge clk);
      #2;
      exp_q.delete();
      in_flight = 0;
      rst_n = 1'b0;
      #1 check_reset_outputs("midrst");
      repeat (3) @(posedge clk);
      #1 check(g, "midrst_no_valid", res_valid, 0);
      rst_n = 1'b1;
      run_one('0, '0, 1'b0);
      check(g, "post_reset_sum", last_sum, 0);

      // Randomised operands with random result backpressure.
      for (int i = 0; i < 30; i++) begin
        res_ready = 1'($urandom);
        send(W'($urandom), W'($urandom), 1'($urandom));
        op_valid = 1'b0;
        if (!res_ready) begin
          wait_valid();
          repeat ($urandom_range(1, 4)) @(posedge clk);
          #1 res_ready = 1'b1;
        end
        wait_idle();
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      n_done++;
    end
  end

  initial begin
    int t = 0;
    while (n_done < 4 && t < 40000) begin @(posedge clk); t++; end
    if (n_done < 4) check(0, "global_timeout", n_done, 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
